// File: rtl/fifo_wide2narrow_flush.sv
// Width-down-converting FIFO with flush.
// WR_WIDTH-bit words go in; RD_WIDTH-bit slices come out, least-significant slice first.
// A flush request discards all contents: one FLUSH cycle clears the pointers while
// holding off the producer, then one DONE cycle pulses flush_done.
module fifo_wide2narrow_flush #(
  parameter  int DEPTH    = 4,
  parameter  int WR_WIDTH = 32,
  parameter  int RD_WIDTH = 4,
  localparam int RATIO    = WR_WIDTH / RD_WIDTH,
  localparam int ADDR     = $clog2(DEPTH),
  localparam int LVL_W    = $clog2(DEPTH * RATIO + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [WR_WIDTH-1:0] wr_data,
  input  logic                rd,
  output logic [RD_WIDTH-1:0] rd_data,
  output logic                vld_rd_data,
  output logic                full,
  output logic                empty,
  output logic [LVL_W-1:0]    level,
  input  logic                flush_req,
  output logic                flush_done
);

  localparam int SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [ADDR:0]    PTR_ONE  = (ADDR + 1)'(1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RATIO - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR:0]         r_wr_ptr;
  logic [ADDR:0]         r_rd_ptr;
  logic [SEL_W-1:0]      r_sel;
  logic [WR_WIDTH-1:0]   r_mem [DEPTH];
  logic [RD_WIDTH-1:0]   r_rd_data;
  logic                  r_vld_rd_data;
  logic                  r_flush_done;

  logic                  w_idle;
  logic                  w_flush_start;
  logic                  w_ptr_full;
  logic                  w_ptr_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_sel_last;
  logic [ADDR:0]         w_used;
  logic [LVL_W-1:0]      w_level_ptr;
  logic [WR_WIDTH-1:0]   w_rd_word;

  // Occupancy is judged on the registered pointers only, so a same-cycle
  // read never opens room for a write and a same-cycle write never feeds a read.
  assign w_idle        = (r_state == ST_IDLE);
  assign w_flush_start = w_idle && flush_req;
  assign w_ptr_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_ptr_full    = (r_wr_ptr[ADDR] != r_rd_ptr[ADDR]) &&
                         (r_wr_ptr[ADDR-1:0] == r_rd_ptr[ADDR-1:0]);
  assign w_wr_acc      = w_idle && !flush_req && wr && !w_ptr_full;
  assign w_rd_acc      = w_idle && !flush_req && rd && !w_ptr_empty;
  assign w_sel_last    = (r_sel == SEL_LAST);
  assign w_used        = r_wr_ptr - r_rd_ptr;
  assign w_level_ptr   = (LVL_W'(w_used) * LVL_W'(RATIO)) - LVL_W'(r_sel);
  assign w_rd_word     = r_mem[r_rd_ptr[ADDR-1:0]];

  // Flush state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush sequencing: IDLE -> FLUSH -> DONE -> IDLE; request sampled only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (flush_req) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Status flags: pointer-derived in IDLE, forced during the flush handshake.
  always_comb begin
    full  = w_ptr_full;
    empty = w_ptr_empty;
    level = w_level_ptr;
    case (r_state)
      ST_IDLE: begin
        full  = w_ptr_full;
        empty = w_ptr_empty;
        level = w_level_ptr;
      end
      ST_FLUSH: begin
        full  = 1'b1;
        empty = 1'b1;
        level = '0;
      end
      ST_DONE: begin
        full  = 1'b0;
        empty = 1'b1;
        level = '0;
      end
      default: begin
        full  = 1'b1;
        empty = 1'b1;
        level = '0;
      end
    endcase
  end

  // Pointer and slice-select update; a flush clears them on entry to FLUSH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sel    <= '0;
    end else if (w_flush_start || (r_state == ST_FLUSH)) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sel    <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        if (w_sel_last) begin
          r_sel    <= '0;
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end else begin
          r_sel    <= r_sel + SEL_ONE;
        end
      end
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR-1:0]] <= wr_data;
    end
  end

  // Registered read slice and valid strobe; data holds when no read is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data     <= '0;
      r_vld_rd_data <= 1'b0;
    end else begin
      r_vld_rd_data <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_word[r_sel*RD_WIDTH +: RD_WIDTH];
      end
    end
  end

  // flush_done is high exactly while in DONE, i.e. the cycle after FLUSH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= (r_state == ST_FLUSH);
    end
  end

  assign rd_data     = r_rd_data;
  assign vld_rd_data = r_vld_rd_data;
  assign flush_done  = r_flush_done;

endmodule

// File: tb/tb_fifo_wide2narrow_flush.sv
// Self-checking bench for fifo_wide2narrow_flush: directed scenarios plus random
// traffic, compared against a slice-queue reference model.
module tb_fifo_wide2narrow_flush;

  localparam int DEPTH    = 4;
  localparam int WR_WIDTH = 32;
  localparam int RD_WIDTH = 4;
  localparam int RATIO    = WR_WIDTH / RD_WIDTH;
  localparam int LVL_W    = $clog2(DEPTH * RATIO + 1);

  logic                clk;
  logic                rst;
  logic                wr;
  logic [WR_WIDTH-1:0] wr_data;
  logic                rd;
  logic [RD_WIDTH-1:0] rd_data;
  logic                vld_rd_data;
  logic                full;
  logic                empty;
  logic [LVL_W-1:0]    level;
  logic                flush_req;
  logic                flush_done;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of unread slices plus flush phase (0 idle, 1 flush, 2 done).
  logic [RD_WIDTH-1:0] q[$];
  int                  m_phase = 0;
  logic                m_vld   = 1'b0;
  logic [RD_WIDTH-1:0] m_rd    = '0;

  fifo_wide2narrow_flush #(
    .DEPTH   (DEPTH),
    .WR_WIDTH(WR_WIDTH),
    .RD_WIDTH(RD_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .wr_data    (wr_data),
    .rd         (rd),
    .rd_data    (rd_data),
    .vld_rd_data(vld_rd_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .flush_req  (flush_req),
    .flush_done (flush_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected flags derived from the model: the FIFO holds whole entries, so it is
  // full once more than DEPTH-1 entries' worth of slices remain unread.
  task automatic chk_all(input string tag);
    logic e_full, e_empty, e_done;
    int   e_level;
    if (m_phase == 1) begin
      e_full = 1'b1; e_empty = 1'b1; e_level = 0;
    end else if (m_phase == 2) begin
      e_full = 1'b0; e_empty = 1'b1; e_level = 0;
    end else begin
      e_full  = (q.size() > (DEPTH - 1) * RATIO);
      e_empty = (q.size() == 0);
      e_level = q.size();
    end
    e_done = (m_phase == 2);
    chk({tag, ".full"},       32'(full),        32'(e_full));
    chk({tag, ".empty"},      32'(empty),       32'(e_empty));
    chk({tag, ".level"},      32'(level),       32'(e_level));
    chk({tag, ".vld"},        32'(vld_rd_data), 32'(m_vld));
    chk({tag, ".rd_data"},    32'(rd_data),     32'(m_rd));
    chk({tag, ".flush_done"}, 32'(flush_done),  32'(e_done));
  endtask

  // One clock cycle: drive inputs, advance the model on pre-edge status, check after edge.
  task automatic cycle(input string tag, input logic w, input logic [WR_WIDTH-1:0] d,
                       input logic r, input logic f);
    logic pre_full, pre_empty;
    logic [WR_WIDTH-1:0] word;
    wr = w; wr_data = d; rd = r; flush_req = f;
    pre_full  = (q.size() > (DEPTH - 1) * RATIO);
    pre_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    m_vld = 1'b0;
    if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (f) begin
      m_phase = 1;
      q.delete();
    end else begin
      if (r && !pre_empty) begin
        m_rd  = q.pop_front();
        m_vld = 1'b1;
      end
      if (w && !pre_full) begin
        word = d;
        for (int k = 0; k < RATIO; k++) begin
          q.push_back(word[k*RD_WIDTH +: RD_WIDTH]);
        end
      end
    end
    chk_all(tag);
  endtask

  initial begin
    logic [WR_WIDTH-1:0] rw;
    wr = 1'b0; wr_data = '0; rd = 1'b0; flush_req = 1'b0;
    rst = 1'b0;

    // 1: reset values
    #12;
    chk_all("t1_reset");
    rst = 1'b1;
    cycle("t1_idle", 1'b0, '0, 1'b0, 1'b0);

    // 2: one word drained slice by slice, LSB first
    cycle("t2_wr", 1'b1, 32'h8765_4321, 1'b0, 1'b0);
    chk("t2_level8", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cycle("t2_rd", 1'b0, '0, 1'b1, 1'b0);
      chk("t2_slice", 32'(rd_data), 32'(i + 1));
    end
    chk("t2_empty", 32'(empty), 32'd1);
    cycle("t2_rd9", 1'b0, '0, 1'b1, 1'b0);
    chk("t2_vld9", 32'(vld_rd_data), 32'd0);

    // 3: fill, drop on full, drain
    cycle("t3_wr0", 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    cycle("t3_wr1", 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    cycle("t3_wr2", 1'b1, 32'h2222_2222, 1'b0, 1'b0);
    cycle("t3_wr3", 1'b1, 32'h3333_3333, 1'b0, 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_level32", 32'(level), 32'd32);
    cycle("t3_wr_drop", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cycle("t3_rd", 1'b0, '0, 1'b1, 1'b0);
      chk("t3_slice", 32'(rd_data), 32'(i / 8));
    end
    chk("t3_empty", 32'(empty), 32'd1);

    // 4: full with sel=7, simultaneous rd+wr rejects the write
    for (int i = 0; i < 4; i++) cycle("t4_fill", 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle("t4_rd", 1'b0, '0, 1'b1, 1'b0);
    cycle("t4_rdwr", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("t4_notfull", 32'(full), 32'd0);
    chk("t4_level24", 32'(level), 32'd24);
    cycle("t4_wr", 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    chk("t4_level32", 32'(level), 32'd32);
    for (int i = 0; i < 32; i++) cycle("t4_drain", 1'b0, '0, 1'b1, 1'b0);

    // 5: flush with a same-cycle read, then normal operation
    cycle("t5_wr0", 1'b1, $urandom, 1'b0, 1'b0);
    cycle("t5_wr1", 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t5_rd", 1'b0, '0, 1'b1, 1'b0);
    cycle("t5_flush", 1'b0, '0, 1'b1, 1'b1);
    chk("t5_fl_full", 32'(full), 32'd1);
    chk("t5_fl_empty", 32'(empty), 32'd1);
    chk("t5_fl_vld", 32'(vld_rd_data), 32'd0);
    cycle("t5_done", 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    chk("t5_done_pulse", 32'(flush_done), 32'd1);
    chk("t5_done_level", 32'(level), 32'd0);
    cycle("t5_after", 1'b0, '0, 1'b0, 1'b0);
    chk("t5_done_low", 32'(flush_done), 32'd0);
    cycle("t5_wr", 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle("t5_rd8", 1'b0, '0, 1'b1, 1'b0);
      chk("t5_slice", 32'(rd_data), (i % 2 == 0) ? 32'h5 : 32'hA);
    end

    // Random traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      rw = $urandom;
      cycle("rnd", 1'($urandom_range(0, 1)), rw, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 40) == 0));
    end

    // 6: asynchronous reset mid-drain at level 13
    cycle("t6_fl", 1'b0, '0, 1'b0, 1'b1);
    cycle("t6_fl2", 1'b0, '0, 1'b0, 1'b0);
    cycle("t6_fl3", 1'b0, '0, 1'b0, 1'b0);
    cycle("t6_wr0", 1'b1, $urandom, 1'b0, 1'b0);
    cycle("t6_wr1", 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t6_rd", 1'b0, '0, 1'b1, 1'b0);
    chk("t6_level13", 32'(level), 32'd13);
    rd = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    q.delete(); m_phase = 0; m_vld = 1'b0; m_rd = '0;
    chk_all("t6_async");
    #3;
    rst = 1'b1;
    cycle("t6_wr", 1'b1, 32'h0FED_CBA9, 1'b0, 1'b0);
    cycle("t6_rd", 1'b0, '0, 1'b1, 1'b0);
    chk("t6_slice", 32'(rd_data), 32'h9);
    for (int i = 0; i < 7; i++) cycle("t6_drain", 1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
